// File: rtl/spc7110_dport.sv
// SPC7110 bank registers ($4830-$4833) and direct data-ROM port ($4810-$4818).
// A two-state prefetch FSM keeps the byte at the data pointer buffered for zero-wait $4810 reads.
module spc7110_dport #(
    parameter logic [23:0] DROM_BASE = 24'h100000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        spc7110_direct_enable,
    input  logic        spc7110_banked_enable,
    input  logic [3:0]  SNES_ADDR_LO,
    input  logic        reg_we,
    input  logic        reg_re_end,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    input  logic [23:0] ROM_MASK,
    output logic        rom_rq,
    output logic [23:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        spc7110_sram_enable,
    output logic [2:0]  spc7110_blockd,
    output logic [2:0]  spc7110_blocke,
    output logic [2:0]  spc7110_blockf
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state, state_next;
    logic [23:0] ptr;
    logic [15:0] ofs;
    logic [15:0] step;
    logic [4:0]  mode;
    logic [7:0]  data_buf;
    logic        dirty;

    logic        wr_direct, wr_banked, consume, set_dirty;
    logic        launch, done;
    logic [23:0] ofs_term, inc, fetch_addr;

    assign wr_direct = reg_we & spc7110_direct_enable;
    assign wr_banked = reg_we & spc7110_banked_enable;
    assign consume   = reg_re_end & spc7110_direct_enable & (SNES_ADDR_LO == 4'd0);
    assign set_dirty = consume |
                       (wr_direct & (SNES_ADDR_LO >= 4'd1) & (SNES_ADDR_LO <= 4'd8));

    assign ofs_term   = !mode[1] ? 24'd0 :
                        mode[3]  ? {{8{ofs[15]}}, ofs} : {8'h00, ofs};
    assign inc        = !mode[0] ? 24'd1 :
                        mode[2]  ? {{8{step[15]}}, step} : {8'h00, step};
    assign fetch_addr = (DROM_BASE + ptr + ofs_term) & ROM_MASK;

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: if (dirty) begin
                launch     = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: if (rom_ack) begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Buffer validity is implied by !dirty with no request outstanding; an early
    // $4810 read simply returns stale data, so no separate flag is kept.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state               <= ST_IDLE;
            ptr                 <= 24'd0;
            ofs                 <= 16'd0;
            step                <= 16'd0;
            mode                <= 5'd0;
            data_buf            <= 8'd0;
            dirty               <= 1'b1;
            rom_rq              <= 1'b0;
            rom_addr            <= 24'd0;
            spc7110_sram_enable <= 1'b0;
            spc7110_blockd      <= 3'd0;
            spc7110_blocke      <= 3'd1;
            spc7110_blockf      <= 3'd2;
        end else begin
            state <= state_next;
            // A write or consume in the launch cycle keeps dirty so the new address is fetched next.
            dirty <= set_dirty | (dirty & ~launch);
            if (launch) begin
                rom_rq   <= 1'b1;
                rom_addr <= fetch_addr;
            end
            if (done) begin
                rom_rq   <= 1'b0;
                data_buf <= rom_data;
            end
            if (consume) begin
                if (mode[4]) ofs <= ofs + inc[15:0];
                else         ptr <= ptr + inc;
            end
            if (wr_direct) begin
                case (SNES_ADDR_LO)
                    4'h1: ptr[7:0]   <= reg_wdata;
                    4'h2: ptr[15:8]  <= reg_wdata;
                    4'h3: ptr[23:16] <= reg_wdata;
                    4'h4: ofs[7:0]   <= reg_wdata;
                    4'h5: ofs[15:8]  <= reg_wdata;
                    4'h6: step[7:0]  <= reg_wdata;
                    4'h7: step[15:8] <= reg_wdata;
                    4'h8: mode       <= reg_wdata[4:0];
                    default: ;
                endcase
            end
            if (wr_banked) begin
                case (SNES_ADDR_LO)
                    4'h0: spc7110_sram_enable <= reg_wdata[7];
                    4'h1: spc7110_blockd      <= reg_wdata[2:0];
                    4'h2: spc7110_blocke      <= reg_wdata[2:0];
                    4'h3: spc7110_blockf      <= reg_wdata[2:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        if (spc7110_direct_enable) begin
            case (SNES_ADDR_LO)
                4'h0: reg_rdata = data_buf;
                4'h1: reg_rdata = ptr[7:0];
                4'h2: reg_rdata = ptr[15:8];
                4'h3: reg_rdata = ptr[23:16];
                4'h4: reg_rdata = ofs[7:0];
                4'h5: reg_rdata = ofs[15:8];
                4'h6: reg_rdata = step[7:0];
                4'h7: reg_rdata = step[15:8];
                4'h8: reg_rdata = {3'b000, mode};
                default: reg_rdata = 8'h00;
            endcase
        end else if (spc7110_banked_enable) begin
            case (SNES_ADDR_LO)
                4'h0: reg_rdata = {spc7110_sram_enable, 7'b0000000};
                4'h1: reg_rdata = {5'b00000, spc7110_blockd};
                4'h2: reg_rdata = {5'b00000, spc7110_blocke};
                4'h3: reg_rdata = {5'b00000, spc7110_blockf};
                default: reg_rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_spc7110_dport.sv
// Directed bench for spc7110_dport: register access, prefetch handshake, pointer/offset stepping.
module tb_spc7110_dport;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        spc7110_direct_enable = 1'b0;
    logic        spc7110_banked_enable = 1'b0;
    logic [3:0]  SNES_ADDR_LO = 4'd0;
    logic        reg_we = 1'b0;
    logic        reg_re_end = 1'b0;
    logic [7:0]  reg_wdata = 8'd0;
    logic [7:0]  reg_rdata;
    logic [23:0] ROM_MASK = 24'hFFFFFF;
    logic        rom_rq;
    logic [23:0] rom_addr;
    logic        rom_ack = 1'b0;
    logic [7:0]  rom_data = 8'd0;
    logic        spc7110_sram_enable;
    logic [2:0]  spc7110_blockd, spc7110_blocke, spc7110_blockf;

    int checks = 0;
    int failures = 0;
    logic [7:0] rd;

    spc7110_dport dut (
        .CLK(CLK), .RST_N(RST_N),
        .spc7110_direct_enable(spc7110_direct_enable),
        .spc7110_banked_enable(spc7110_banked_enable),
        .SNES_ADDR_LO(SNES_ADDR_LO), .reg_we(reg_we), .reg_re_end(reg_re_end),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .ROM_MASK(ROM_MASK),
        .rom_rq(rom_rq), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .spc7110_sram_enable(spc7110_sram_enable),
        .spc7110_blockd(spc7110_blockd), .spc7110_blocke(spc7110_blocke),
        .spc7110_blockf(spc7110_blockf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic banked, input logic [3:0] idx, input logic [7:0] d);
        @(negedge CLK);
        spc7110_direct_enable = !banked;
        spc7110_banked_enable = banked;
        SNES_ADDR_LO = idx;
        reg_wdata = d;
        reg_we = 1'b1;
        @(negedge CLK);
        reg_we = 1'b0;
        spc7110_direct_enable = 1'b0;
        spc7110_banked_enable = 1'b0;
    endtask

    task automatic rd_reg(input logic banked, input logic [3:0] idx, output logic [7:0] d);
        @(negedge CLK);
        spc7110_direct_enable = !banked;
        spc7110_banked_enable = banked;
        SNES_ADDR_LO = idx;
        #1 d = reg_rdata;
        spc7110_direct_enable = 1'b0;
        spc7110_banked_enable = 1'b0;
    endtask

    // Full $4810 read: sample data, then end-of-read pulse advances the pointer.
    task automatic rd_port(output logic [7:0] d);
        @(negedge CLK);
        spc7110_direct_enable = 1'b1;
        SNES_ADDR_LO = 4'd0;
        #1 d = reg_rdata;
        reg_re_end = 1'b1;
        @(negedge CLK);
        reg_re_end = 1'b0;
        spc7110_direct_enable = 1'b0;
    endtask

    task automatic wait_rq(input int budget);
        int n = 0;
        while (!rom_rq && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (!rom_rq) chk("rq_timeout", {31'd0, rom_rq}, 32'd1);
    endtask

    task automatic ack(input logic [7:0] d);
        rom_ack = 1'b1;
        rom_data = d;
        @(negedge CLK);
        rom_ack = 1'b0;
    endtask

    // Ack any stale requests until the expected address is presented, then deliver data.
    task automatic serve(input string tag, input logic [23:0] exp, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            wait_rq(10);
            if (rom_addr == exp) break;
            ack(8'h00);
        end
        chk(tag, {8'd0, rom_addr}, {8'd0, exp});
        ack(d);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_rq", {31'd0, rom_rq}, 32'd0);
        chk("rst_blockd", {29'd0, spc7110_blockd}, 32'd0);
        chk("rst_blocke", {29'd0, spc7110_blocke}, 32'd1);
        chk("rst_blockf", {29'd0, spc7110_blockf}, 32'd2);
        chk("rst_sram", {31'd0, spc7110_sram_enable}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_rq(2);
        chk("rst_fetch_addr", {8'd0, rom_addr}, 32'h100000);
        ack(8'h00);
        rd_reg(1'b1, 4'h2, rd); chk("rd_4832", {24'd0, rd}, 32'h01);
        rd_reg(1'b0, 4'hF, rd); chk("rd_481f", {24'd0, rd}, 32'h00);

        // Pointer write, unsigned default stepping
        wr(1'b0, 4'h1, 8'h45);
        wr(1'b0, 4'h2, 8'h23);
        wr(1'b0, 4'h3, 8'h01);
        serve("ptr_fetch", 24'h112345, 8'hA5);
        rd_port(rd); chk("rd_4810_a5", {24'd0, rd}, 32'hA5);
        wait_rq(4);
        chk("ptr_inc_fetch", {8'd0, rom_addr}, 32'h112346);
        ack(8'h5A);
        rd_reg(1'b0, 4'h1, rd); chk("ptr_lo_46", {24'd0, rd}, 32'h46);
        rd_reg(1'b0, 4'h3, rd); chk("ptr_hi_01", {24'd0, rd}, 32'h01);

        // Bank registers: immediate effect, no refetch
        wr(1'b1, 4'h0, 8'hFF);
        chk("sram_en", {31'd0, spc7110_sram_enable}, 32'd1);
        wr(1'b1, 4'h1, 8'hFD);
        chk("blockd_5", {29'd0, spc7110_blockd}, 32'd5);
        rd_reg(1'b1, 4'h0, rd); chk("rd_4830", {24'd0, rd}, 32'h80);
        rd_reg(1'b1, 4'h1, rd); chk("rd_4831", {24'd0, rd}, 32'h05);
        repeat (3) @(negedge CLK);
        chk("bank_no_rq", {31'd0, rom_rq}, 32'd0);

        // Signed offset and signed step
        wr(1'b0, 4'h8, 8'h0F);
        wr(1'b0, 4'h4, 8'hFE);
        wr(1'b0, 4'h5, 8'hFF);
        wr(1'b0, 4'h6, 8'h00);
        wr(1'b0, 4'h7, 8'h80);
        wr(1'b0, 4'h1, 8'h10);
        wr(1'b0, 4'h2, 8'h00);
        wr(1'b0, 4'h3, 8'h00);
        serve("signed_fetch", 24'h10000E, 8'h77);
        rd_reg(1'b0, 4'h8, rd); chk("rd_mode", {24'd0, rd}, 32'h0F);
        rd_port(rd); chk("rd_4810_77", {24'd0, rd}, 32'h77);
        wait_rq(4);
        chk("signed_step_fetch", {8'd0, rom_addr}, 32'h0F800E);
        ack(8'h00);
        rd_reg(1'b0, 4'h3, rd); chk("ptr_hi_ff", {24'd0, rd}, 32'hFF);
        rd_reg(1'b0, 4'h2, rd); chk("ptr_mid_80", {24'd0, rd}, 32'h80);

        // Step applied to unsigned offset
        wr(1'b0, 4'h8, 8'h13);
        wr(1'b0, 4'h6, 8'h02);
        wr(1'b0, 4'h7, 8'h00);
        wr(1'b0, 4'h4, 8'hFF);
        wr(1'b0, 4'h5, 8'hFF);
        serve("ofs_fetch", 24'h10800F, 8'h11);
        rd_port(rd); chk("rd_4810_11", {24'd0, rd}, 32'h11);
        wait_rq(4);
        chk("ofs_step_fetch", {8'd0, rom_addr}, 32'h0F8011);
        ack(8'h00);
        rd_reg(1'b0, 4'h4, rd); chk("ofs_lo_01", {24'd0, rd}, 32'h01);
        rd_reg(1'b0, 4'h5, rd); chk("ofs_hi_00", {24'd0, rd}, 32'h00);
        rd_reg(1'b0, 4'h1, rd); chk("ptr_lo_kept", {24'd0, rd}, 32'h10);

        // Dirty while request outstanding
        wr(1'b0, 4'h8, 8'h00);
        wait_rq(4);
        chk("pre_dirty_addr", {8'd0, rom_addr}, 32'h0F8010);
        wr(1'b0, 4'h3, 8'h02);
        chk("rq_held", {31'd0, rom_rq}, 32'd1);
        chk("addr_stable", {8'd0, rom_addr}, 32'h0F8010);
        ack(8'hEE);
        chk("rq_drop_after_ack", {31'd0, rom_rq}, 32'd0);
        wait_rq(3);
        chk("refetch_addr", {8'd0, rom_addr}, 32'h128010);
        rd_reg(1'b0, 4'h0, rd); chk("stale_buf", {24'd0, rd}, 32'hEE);
        ack(8'h33);
        rd_reg(1'b0, 4'h0, rd); chk("refetch_buf", {24'd0, rd}, 32'h33);

        // Pointer wrap at 2^24
        wr(1'b0, 4'h1, 8'hFF);
        wr(1'b0, 4'h2, 8'hFF);
        wr(1'b0, 4'h3, 8'hFF);
        serve("wrap_pre_fetch", 24'h0FFFFF, 8'h44);
        rd_port(rd); chk("rd_4810_44", {24'd0, rd}, 32'h44);
        wait_rq(4);
        chk("wrap_fetch", {8'd0, rom_addr}, 32'h100000);
        rd_reg(1'b0, 4'h1, rd); chk("wrap_ptr_lo", {24'd0, rd}, 32'h00);
        rd_reg(1'b0, 4'h3, rd); chk("wrap_ptr_hi", {24'd0, rd}, 32'h00);

        // Consume and ack in the same cycle
        @(negedge CLK);
        spc7110_direct_enable = 1'b1;
        SNES_ADDR_LO = 4'd0;
        reg_re_end = 1'b1;
        rom_ack = 1'b1;
        rom_data = 8'h99;
        @(negedge CLK);
        reg_re_end = 1'b0;
        rom_ack = 1'b0;
        spc7110_direct_enable = 1'b0;
        chk("coll_rq_drop", {31'd0, rom_rq}, 32'd0);
        wait_rq(3);
        chk("coll_refetch", {8'd0, rom_addr}, 32'h100001);
        rd_reg(1'b0, 4'h0, rd); chk("coll_buf", {24'd0, rd}, 32'h99);

        // Async reset mid-request
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_rq", {31'd0, rom_rq}, 32'd0);
        chk("async_rst_blockd", {29'd0, spc7110_blockd}, 32'd0);
        chk("async_rst_sram", {31'd0, spc7110_sram_enable}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
